// File: rtl/stream_sample_packer.sv
// Packs little-endian, L-then-R interleaved PCM payload bytes into stereo
// 32-bit MSB-justified frames, with valid/ready handshakes on both sides.
module stream_sample_packer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             flush_i,
  input  logic [1:0]       bit_depth_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  output logic             byte_ready_o,
  output logic             sample_valid_o,
  output logic [31:0]      sample_left_o,
  output logic [31:0]      sample_right_o,
  input  logic             sample_ready_i,
  output logic             err_o,
  output logic [CNT_W-1:0] frame_count_o
);

  typedef enum logic {S_COLLECT = 1'b0, S_PRESENT = 1'b1} state_t;

  state_t           r_state;
  logic [2:0]       r_idx;
  logic [1:0]       r_dep;
  logic [31:0]      r_left;
  logic [31:0]      r_right;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0] w_dep;
  logic [2:0] w_nb;
  logic [2:0] w_last;
  logic       w_to_left;
  logic [1:0] w_lane;

  // Depth is taken live on the first byte of a frame, then from the latch.
  assign w_dep     = (r_idx == 3'd0) ? bit_depth_i : r_dep;
  assign w_nb      = {1'b0, w_dep} + 3'd2;
  assign w_last    = {w_dep, 1'b0} + 3'd3;
  assign w_to_left = (r_idx < w_nb);
  // Byte lane within the 32-bit word (lane 3 = bits 31:24).
  assign w_lane    = w_to_left ? 2'(3'd2 - {1'b0, w_dep} + r_idx)
                               : 2'(r_idx - {w_dep, 1'b0});

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_COLLECT;
      r_idx   <= '0;
      r_dep   <= '0;
      r_left  <= '0;
      r_right <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (flush_i) begin
      r_state <= S_COLLECT;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (byte_valid_i) begin
            if (r_idx == 3'd0 && bit_depth_i == 2'b11) begin
              r_err <= 1'b1;
            end else begin
              // First byte clears the frame so unused low bits read as zero.
              if (r_idx == 3'd0) begin
                r_dep   <= bit_depth_i;
                r_left  <= 32'(byte_data_i) << {w_lane, 3'b000};
                r_right <= '0;
              end else if (w_to_left) begin
                r_left[{w_lane, 3'b000} +: 8] <= byte_data_i;
              end else begin
                r_right[{w_lane, 3'b000} +: 8] <= byte_data_i;
              end
              if (r_idx == w_last) begin
                r_idx   <= '0;
                r_state <= S_PRESENT;
              end else begin
                r_idx <= r_idx + 3'd1;
              end
            end
          end
        end
        S_PRESENT: begin
          if (sample_ready_i) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_state <= S_COLLECT;
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

  assign byte_ready_o   = (r_state == S_COLLECT);
  assign sample_valid_o = (r_state == S_PRESENT);
  assign sample_left_o  = r_left;
  assign sample_right_o = r_right;
  assign err_o          = r_err;
  assign frame_count_o  = r_cnt;

endmodule

// File: tb/tb_stream_sample_packer.sv
// Scoreboard bench: driver runs a byte-queue reference model and pushes
// expected frames; a negedge monitor pops them on each delivered frame.
module tb_stream_sample_packer;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic [1:0]       depth;
  logic             bvalid;
  logic [7:0]       bdata;
  logic             bready;
  logic             svalid;
  logic [31:0]      sleft;
  logic [31:0]      sright;
  logic             sready;
  logic             err;
  logic [CNT_W-1:0] fcount;

  always #5 clk = ~clk;

  stream_sample_packer #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush), .bit_depth_i(depth),
    .byte_valid_i(bvalid), .byte_data_i(bdata), .byte_ready_o(bready),
    .sample_valid_o(svalid), .sample_left_o(sleft), .sample_right_o(sright),
    .sample_ready_i(sready), .err_o(err), .frame_count_o(fcount)
  );

  typedef struct { logic [31:0] l; logic [31:0] r; } frame_t;

  frame_t           exp_q[$];
  int               n_vec = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  bit               mon_en = 1'b0;

  // Reference model state: bytes of the frame in progress, held flag, error.
  bit               m_hold = 1'b0;
  bit               m_err = 1'b0;
  int               m_dep = 0;
  byte unsigned     m_bytes[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic frame_t pack(input int dep, input byte unsigned b[$]);
    frame_t f;
    int nb;
    nb = dep + 2;
    f.l = '0;
    f.r = '0;
    for (int i = 0; i < nb; i++) begin
      f.l = f.l | (32'(b[i])      << (8 * (4 - nb + i)));
      f.r = f.r | (32'(b[nb + i]) << (8 * (4 - nb + i)));
    end
    return f;
  endfunction

  task automatic model(input bit fl, input logic [1:0] dp, input bit bv,
                       input logic [7:0] bd, input bit sr);
    if (fl) begin
      m_bytes.delete();
      m_hold = 1'b0;
      m_err  = 1'b0;
    end else if (m_hold) begin
      if (sr) m_hold = 1'b0;
    end else if (bv) begin
      if (m_bytes.size() == 0 && dp == 2'b11) begin
        m_err = 1'b1;
      end else begin
        if (m_bytes.size() == 0) m_dep = int'(dp);
        m_bytes.push_back(bd);
        if (m_bytes.size() == 2 * (m_dep + 2)) begin
          exp_q.push_back(pack(m_dep, m_bytes));
          m_bytes.delete();
          m_hold = 1'b1;
        end
      end
    end
  endtask

  // Called just after a posedge; drives one cycle and advances the model.
  task automatic step(input bit fl, input logic [1:0] dp, input bit bv,
                      input logic [7:0] bd, input bit sr);
    flush = fl; depth = dp; bvalid = bv; bdata = bd; sready = sr;
    @(posedge clk);
    #1;
    model(fl, dp, bv, bd, sr);
    chk("byte_ready", bready, !m_hold);
    chk("sample_valid", svalid, m_hold);
    chk("err", err, m_err);
  endtask

  task automatic send(input logic [1:0] dp, input logic [7:0] first,
                      input int n, input bit sr);
    for (int i = 0; i < n; i++) step(1'b0, dp, 1'b1, first + 8'(i), sr);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("frame_present", svalid, exp_q.size() != 0);
      if (svalid && exp_q.size() != 0) begin
        chk("count_held", fcount, exp_cnt);
        if (flush) begin
          void'(exp_q.pop_front());
        end else if (sready) begin
          frame_t f;
          f = exp_q.pop_front();
          chk("left", sleft, f.l);
          chk("right", sright, f.r);
          exp_cnt = exp_cnt + 1'b1;
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; flush = 1'b0; depth = 2'b00; bvalid = 1'b0;
    bdata = 8'h00; sready = 1'b0;
    #2;
    chk("rst_ready", bready, 1'b1);
    chk("rst_valid", svalid, 1'b0);
    chk("rst_left", sleft, 32'h0);
    chk("rst_right", sright, 32'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_count", fcount, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // 16-bit frame, taken immediately
    send(2'b00, 8'h01, 4, 1'b1);
    chk("t1_left", sleft, 32'h0201_0000);
    chk("t1_right", sright, 32'h0403_0000);
    step(1'b0, 2'b00, 1'b0, 8'h00, 1'b1);
    chk("t1_count", fcount, 32'd1);

    // 24-bit and 32-bit frames
    send(2'b01, 8'h11, 6, 1'b1);
    chk("t2a_left", sleft, 32'h1312_1100);
    chk("t2a_right", sright, 32'h1615_1400);
    step(1'b0, 2'b01, 1'b0, 8'h00, 1'b1);
    send(2'b10, 8'h21, 8, 1'b1);
    chk("t2b_left", sleft, 32'h2423_2221);
    chk("t2b_right", sright, 32'h2827_2625);
    step(1'b0, 2'b10, 1'b0, 8'h00, 1'b1);

    // Backpressure: frame held, incoming bytes refused
    send(2'b00, 8'h31, 4, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'b00, 1'b1, 8'hAA, 1'b0);
      chk("t3_left_hold", sleft, 32'h3231_0000);
      chk("t3_right_hold", sright, 32'h3433_0000);
      chk("t3_count_hold", fcount, 32'd3);
    end
    step(1'b0, 2'b00, 1'b0, 8'h00, 1'b1);
    chk("t3_count", fcount, 32'd4);

    // Depth change mid-frame applies to the next frame
    step(1'b0, 2'b00, 1'b1, 8'h41, 1'b0);
    send(2'b01, 8'h42, 3, 1'b0);
    chk("t4_left", sleft, 32'h4241_0000);
    chk("t4_right", sright, 32'h4443_0000);
    step(1'b0, 2'b01, 1'b0, 8'h00, 1'b1);
    send(2'b01, 8'h51, 6, 1'b1);
    chk("t4_next_left", sleft, 32'h5352_5100);
    step(1'b0, 2'b01, 1'b0, 8'h00, 1'b1);

    // Flush after 3 bytes; byte presented with flush is dropped
    send(2'b00, 8'h61, 3, 1'b0);
    step(1'b1, 2'b00, 1'b1, 8'h64, 1'b0);
    send(2'b00, 8'h01, 4, 1'b1);
    chk("t5_left", sleft, 32'h0201_0000);
    chk("t5_right", sright, 32'h0403_0000);
    step(1'b0, 2'b00, 1'b0, 8'h00, 1'b1);
    chk("t5_count", fcount, 32'd7);

    // Reserved depth: byte discarded, sticky error, cleared by flush
    step(1'b0, 2'b11, 1'b1, 8'h77, 1'b0);
    chk("t6_err", err, 1'b1);
    send(2'b00, 8'h81, 4, 1'b1);
    chk("t6_left", sleft, 32'h8281_0000);
    step(1'b0, 2'b00, 1'b0, 8'h00, 1'b1);
    chk("t6_err_sticky", err, 1'b1);
    step(1'b1, 2'b00, 1'b0, 8'h00, 1'b0);
    chk("t6_err_clr", err, 1'b0);

    // Random traffic; long enough to wrap the 8-bit counter
    for (int c = 0; c < 4000; c++) begin
      bit          fl, bv, sr;
      logic [1:0]  dp;
      fl = ($urandom % 100) == 0;
      dp = (($urandom % 20) == 0) ? 2'b11 : 2'($urandom % 3);
      bv = ($urandom % 4) != 0;
      sr = ($urandom % 3) != 0;
      step(fl, dp, bv, 8'($urandom), sr);
    end

    // Async reset mid-frame
    step(1'b1, 2'b00, 1'b0, 8'h00, 1'b0);
    step(1'b0, 2'b11, 1'b1, 8'h99, 1'b0);
    send(2'b10, 8'hA1, 3, 1'b0);
    bvalid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ready", bready, 1'b1);
    chk("arst_valid", svalid, 1'b0);
    chk("arst_left", sleft, 32'h0);
    chk("arst_right", sright, 32'h0);
    chk("arst_err", err, 1'b0);
    chk("arst_count", fcount, 32'h0);
    m_bytes.delete();
    m_hold = 1'b0;
    m_err = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
    @(negedge clk);
    #1 reset_n = 1'b1;
    send(2'b10, 8'hB1, 8, 1'b1);
    chk("post_rst_left", sleft, 32'hB4B3_B2B1);
    step(1'b0, 2'b10, 1'b0, 8'h00, 1'b1);
    chk("post_rst_count", fcount, 32'd1);
    step(1'b0, 2'b00, 1'b0, 8'h00, 1'b0);

    mon_en = 1'b0;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
